// File: rtl/calc_seq_param.sv
// Sequential calculator: WIDTH-bit add/sub/and/xor, iterative shift-add multiply and
// restoring divide with a double-width result. The divider is built only when CALC_DIV_EN is defined.
module calc_seq_param #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Go,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [3:0]       CSout,
    output logic             Done,
    output logic             Err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        EXEC = 4'd2,
        MUL  = 4'd3,
        DIV  = 4'd4,
        DONE = 4'd5,
        ERR  = 4'd6
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic [2:0]             opr_r;
    logic [CW-1:0]          cnt_r;
    logic [2*WIDTH-1:0]     prod_r;
    logic [WIDTH-1:0]       out_r;
    logic [WIDTH-1:0]       hi_r;
    logic                   done_r;
    logic                   err_r;

    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         dif_s;
    logic [WIDTH-1:0]       alu_out_s;
    logic [WIDTH-1:0]       alu_hi_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     mul_next_s;
`ifdef CALC_DIV_EN
    logic [WIDTH:0]         div_shift_s;
    logic                   div_ge_s;
    logic [WIDTH-1:0]       div_sub_s;
    logic [2*WIDTH-1:0]     div_next_s;
`endif

    assign out   = out_r;
    assign hi    = hi_r;
    assign CSout = state_r;
    assign Done  = done_r;
    assign Err   = err_r;

    // Next-state decode; unused codes fall back to IDLE
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (Go) state_next_s = LOAD;
                else    state_next_s = IDLE;
            end
            LOAD: begin
                case (opr_r)
                    3'b000, 3'b001, 3'b010, 3'b011: state_next_s = EXEC;
                    3'b100:                         state_next_s = MUL;
`ifdef CALC_DIV_EN
                    3'b101: begin
                        if (b_r == {WIDTH{1'b0}}) state_next_s = ERR;
                        else                      state_next_s = DIV;
                    end
`endif
                    default:                        state_next_s = ERR;
                endcase
            end
            EXEC: state_next_s = DONE;
            MUL: begin
                if (cnt_r == CW'(1)) state_next_s = DONE;
                else                 state_next_s = MUL;
            end
`ifdef CALC_DIV_EN
            DIV: begin
                if (cnt_r == CW'(1)) state_next_s = DONE;
                else                 state_next_s = DIV;
            end
`endif
            DONE:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Single-cycle ALU; the extra bit of sum/difference is the carry/borrow
    always_comb begin
        sum_s     = {1'b0, a_r} + {1'b0, b_r};
        dif_s     = {1'b0, a_r} - {1'b0, b_r};
        alu_out_s = {WIDTH{1'b0}};
        alu_hi_s  = {WIDTH{1'b0}};
        case (opr_r[1:0])
            2'b00: begin
                alu_out_s = sum_s[WIDTH-1:0];
                alu_hi_s  = {{(WIDTH-1){1'b0}}, sum_s[WIDTH]};
            end
            2'b01: begin
                alu_out_s = dif_s[WIDTH-1:0];
                alu_hi_s  = {{(WIDTH-1){1'b0}}, dif_s[WIDTH]};
            end
            2'b10:   alu_out_s = a_r & b_r;
            2'b11:   alu_out_s = a_r ^ b_r;
            default: alu_out_s = {WIDTH{1'b0}};
        endcase
    end

    // Shift-add step: prod_r holds {partial, multiplier}; add A on LSB, then shift right
    always_comb begin
        mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                   + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
    end

`ifdef CALC_DIV_EN
    // Restoring step: prod_r holds {remainder, dividend/quotient}
    always_comb begin
        div_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        div_sub_s   = div_shift_s[WIDTH-1:0] - b_r;
        div_next_s  = {(div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0]),
                       prod_r[WIDTH-2:0], div_ge_s};
    end
`endif

    // State, operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            opr_r   <= 3'b000;
            cnt_r   <= {CW{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            out_r   <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE) || (state_next_s == ERR);
            err_r   <= (state_next_s == ERR);
            case (state_r)
                IDLE: begin
                    if (Go) begin
                        a_r   <= in1;
                        b_r   <= in2;
                        opr_r <= Op;
                    end
                end
                LOAD: begin
                    cnt_r  <= CW'(WIDTH);
                    prod_r <= (opr_r == 3'b100) ? {{WIDTH{1'b0}}, b_r} : {{WIDTH{1'b0}}, a_r};
                    if (state_next_s == ERR) begin
                        out_r <= {WIDTH{1'b0}};
                        hi_r  <= {WIDTH{1'b0}};
                    end
                end
                EXEC: begin
                    out_r <= alu_out_s;
                    hi_r  <= alu_hi_s;
                end
                MUL: begin
                    prod_r <= mul_next_s;
                    cnt_r  <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        out_r <= mul_next_s[WIDTH-1:0];
                        hi_r  <= mul_next_s[2*WIDTH-1:WIDTH];
                    end
                end
`ifdef CALC_DIV_EN
                DIV: begin
                    prod_r <= div_next_s;
                    cnt_r  <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        out_r <= div_next_s[WIDTH-1:0];
                        hi_r  <= div_next_s[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_param.sv
// Bench for calc_seq_param: transaction-level schedule model checked every cycle,
// directed literal checks from the test plan, then randomized traffic with occasional reset.
module tb_calc_seq_param;

    localparam int W = 3;
`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         Go;
    logic [2:0]   Op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic [3:0]   CSout;
    logic         Done;
    logic         Err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Go(Go), .Op(Op), .in1(in1), .in2(in2),
        .out(out), .hi(hi), .CSout(CSout), .Done(Done), .Err(Err)
    );

    typedef struct {
        int cs;
        bit done;
        bit err;
        int o;
        int h;
    } exp_t;

    exp_t sched[$];
    exp_t cur;
    bit   chk_en = 1'b0;
    logic [3:0] cs_seq [0:7];

    function automatic exp_t mk(int cs, bit d, bit e, int o, int h);
        exp_t x;
        x.cs = cs; x.done = d; x.err = e; x.o = o; x.h = h;
        return x;
    endfunction

    // Build the whole per-cycle outcome of one captured operation from plain arithmetic
    function automatic void plan(int a, int b, int op);
        int m = 1 << W;
        int ro = 0, rh = 0, bcs = 2, bn = 1;
        bit bad = 1'b0;
        case (op)
            0: begin ro = (a + b) % m; rh = (a + b) / m; end
            1: begin ro = (a - b + m) % m; rh = (a < b) ? 1 : 0; end
            2: begin ro = a & b; rh = 0; end
            3: begin ro = a ^ b; rh = 0; end
            4: begin ro = (a * b) % m; rh = (a * b) / m; bcs = 3; bn = W; end
            5: begin
                if (DIV_EN && b != 0) begin ro = a / b; rh = a % b; bcs = 4; bn = W; end
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        sched.push_back(mk(1, 1'b0, 1'b0, cur.o, cur.h));
        if (bad) sched.push_back(mk(6, 1'b1, 1'b1, 0, 0));
        else begin
            repeat (bn) sched.push_back(mk(bcs, 1'b0, 1'b0, cur.o, cur.h));
            sched.push_back(mk(5, 1'b1, 1'b0, ro, rh));
        end
    endfunction

    // Reference model advances on every rising edge
    initial forever begin
        @(posedge clk);
        if (rst) begin
            sched.delete();
            cur = mk(0, 1'b0, 1'b0, 0, 0);
            chk_en = 1'b1;
        end else if (chk_en) begin
            if (sched.size() == 0 && cur.cs == 0 && Go) plan(int'(in1), int'(in2), int'(Op));
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = mk(0, 1'b0, 1'b0, cur.o, cur.h);
        end
    end

    // Compare DUT against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (int'(CSout) != cur.cs || Done !== cur.done || Err !== cur.err ||
                int'(out) != cur.o || int'(hi) != cur.h) begin
                errors++;
                $display("FAIL model_cmp t=%0t got cs=%0d done=%0b err=%0b out=%0d hi=%0d want cs=%0d done=%0b err=%0b out=%0d hi=%0d",
                         $time, CSout, Done, Err, out, hi, cur.cs, cur.done, cur.err, cur.o, cur.h);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Start one op, scramble inputs after capture, wait (bounded) for Done, check literals
    task automatic run_op(input string nm, input logic [2:0] op, input int a, input int b,
                          input int eo, input int eh, input int ee, input int elat);
        int lat = 0;
        @(negedge clk);
        Go = 1'b1; Op = op; in1 = W'(a); in2 = W'(b);
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            Go = 1'b0; Op = 3'($urandom); in1 = W'($urandom); in2 = W'($urandom);
            if (lat < 8) cs_seq[lat] = CSout;
            if (Done) break;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_out"}, int'(out), eo);
        chk({nm, "_hi"}, int'(hi), eh);
        chk({nm, "_err"}, int'(Err), ee);
    endtask

    initial begin
        int lat;
        bit seen;
        rst = 1'b1; Go = 1'b0; Op = 3'b000; in1 = '0; in2 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cs", int'(CSout), 0);
        chk("reset_out", int'(out), 0);
        chk("reset_hi", int'(hi), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_err", int'(Err), 0);
        rst = 1'b0;

        run_op("add", 3'b000, 5, 2, 7, 0, 0, 3);
        chk("add_cs1", int'(cs_seq[1]), 1);
        chk("add_cs2", int'(cs_seq[2]), 2);
        chk("add_cs3", int'(cs_seq[3]), 5);
        @(negedge clk);
        chk("add_cs_idle", int'(CSout), 0);
        chk("add_done_1cyc", int'(Done), 0);

        run_op("sub", 3'b001, 2, 5, 5, 1, 0, 3);
        run_op("xor", 3'b011, 6, 3, 5, 0, 0, 3);
        run_op("mul", 3'b100, 5, 7, 3, 4, 0, 5);
        chk("mul_cs2", int'(cs_seq[2]), 3);
        chk("mul_cs4", int'(cs_seq[4]), 3);
        if (DIV_EN) begin
            run_op("div", 3'b101, 7, 2, 3, 1, 0, 5);
            chk("div_cs2", int'(cs_seq[2]), 4);
            run_op("div0", 3'b101, 5, 0, 0, 0, 1, 2);
        end else begin
            run_op("div_off", 3'b101, 7, 2, 0, 0, 1, 2);
            chk("div_off_cs", int'(cs_seq[2]), 6);
        end
        run_op("illegal", 3'b110, 1, 1, 0, 0, 1, 2);
        run_op("add2", 3'b000, 3, 3, 6, 0, 0, 3);

        // Reset while a multiply is in flight
        @(negedge clk);
        Go = 1'b1; Op = 3'b100; in1 = 3'd7; in2 = 3'd7;
        @(negedge clk);
        Go = 1'b0;
        @(negedge clk);
        chk("rst_mul_running", int'(CSout), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_cs", int'(CSout), 0);
        chk("rst_mid_out", int'(out), 0);
        chk("rst_mid_done", int'(Done), 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (Done) seen = 1'b1;
        end
        chk("rst_no_done", int'(seen), 0);

        // Go held high: back-to-back operations with one IDLE cycle between
        Go = 1'b1; Op = 3'b010; in1 = 3'd6; in2 = 3'd3;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!Done && lat < 40);
        chk("b2b_latency", lat, 3);
        chk("b2b_out", int'(out), 2);
        @(negedge clk);
        chk("b2b_idle", int'(CSout), 0);
        @(negedge clk);
        chk("b2b_load", int'(CSout), 1);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!Done && lat < 40);
        chk("b2b2_latency", lat, 2);
        chk("b2b2_out", int'(out), 2);
        Go = 1'b0;

        // Randomized traffic; the model checks every cycle
        repeat (600) begin
            @(negedge clk);
            rst = ($urandom_range(0, 79) == 0);
            Go  = ($urandom_range(0, 2) == 0);
            Op  = 3'($urandom);
            in1 = W'($urandom);
            in2 = W'($urandom);
        end
        rst = 1'b0;
        Go  = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_seq_param.md
# calc_seq_param

Parametrised sequential calculator: datapath plus Moore control FSM, WIDTH-bit operands, Go-started operations. Single-cycle ALU ops plus multi-cycle iterative multiply and divide, with a double-width result (out/hi), current-state export (CSout) and an error flag. Next-generation replacement for the fixed 3-bit, 2-bit-op calculator datapath; drops into the same bench wiring with added ports.

## Interface
- WIDTH, 3: operand and result-half width; legal range 2–16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Go  input  1  start request, level-sampled in IDLE.
- Op  input  3  000 add, 001 sub, 010 and, 011 xor, 100 mul, 101 div, 110/111 illegal.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out  output  WIDTH  result low half.
- hi  output  WIDTH  result high half: carry/borrow, product MSBs, or remainder.
- CSout  output  4  current FSM state code.
- Done  output  1  high for exactly the one cycle spent in DONE or ERR.
- Err  output  1  high only in ERR.

## Operation
- States (CSout): IDLE=0, LOAD=1, EXEC=2, MUL=3, DIV=4, DONE=5, ERR=6; codes 7–15 unreachable and decode to IDLE.
- IDLE: Go=1 at edge → capture in1→A, in2→B, Op→OPR; go to LOAD. Go=0 → stay in IDLE.
- LOAD: decode OPR.
  - 000–011 → EXEC.
  - 100 → MUL, counter=WIDTH.
  - 101 → DIV, counter=WIDTH; if B==0 → ERR instead.
  - 110/111 → ERR.
- EXEC: write result and go to DONE.
  - add: {hi,out} = {0…, carry, A+B mod 2^W}.
  - sub: out = A−B mod 2^W, hi[0] = borrow (A<B).
  - and/xor: hi = 0.
- MUL: unsigned shift-add, one partial-product step per cycle. The edge that decrements the counter to 0 writes the 2W-bit product to {hi,out} and enters DONE.
- DIV: unsigned restoring division, one quotient bit per cycle. The final step writes out=quotient, hi=remainder and enters DONE.
- DONE → IDLE unconditionally.
- ERR: out=0, hi=0 written on entry; ERR → IDLE.
- out/hi hold their last written value through IDLE and LOAD; they change only on completion, error or reset.
- in1/in2/Op changes after the capture edge are ignored until the next IDLE capture.
- Go held high continuously: a new operation is captured on the edge leaving IDLE, giving back-to-back operations with one IDLE cycle between them.
- All arithmetic is unsigned; no sign extension.

## Timing
- Reset: rst=1 at an edge → state IDLE, out=0, hi=0, CSout=0, Done=0, Err=0, counter=0, internal A/B/OPR=0. rst has priority over Go and over any in-flight MUL/DIV; the operation is abandoned with no Done.
- Let the capture edge be k.
- LOAD occupies k..k+1.
- Single-cycle ops: EXEC during k+1..k+2; Done=1 during k+2..k+3.
- MUL/DIV: WIDTH cycles in MUL/DIV; Done=1 during k+1+WIDTH..k+2+WIDTH (WIDTH=3: Done after edge k+4).
- Error path: ERR during k+1..k+2 with Done=1 and Err=1.
- All outputs are registered (Moore); no combinational input→output path.

## Configuration
- CALC_DIV_EN defined: DIV state, divider datapath and op 101 present, as specified above.
- CALC_DIV_EN undefined: DIV logic not compiled. Op 101 is treated as illegal and goes LOAD → ERR; CSout never shows 4.

## Test plan
- WIDTH=3, rst one cycle, then Go=1, Op=000, in1=5, in2=2 → out=7, hi=0, Done high one cycle at capture+2, CSout sequence 0,1,2,5,0.
- Op=001, in1=2, in2=5 → out=3'b101, hi=3'b001.
- Op=011, in1=6, in2=3 → out=5, hi=0.
- Op=100, in1=5, in2=7 → {hi,out}=6'b100011 (35), Done at capture+4, CSout holds 3 for 3 cycles.
  - Change in1 to 0 mid-operation → result unchanged.
- With CALC_DIV_EN: Op=101, 7/2 → out=3, hi=1.
  - 5/0 → Err=1 and Done=1 for one cycle, out=0, hi=0.
  - Without CALC_DIV_EN: Op=101 → ERR.
- Op=110 → Err pulse.
- MUL in progress, rst=1 for one edge → next cycle CSout=0, out=0, Done never pulses.
- Then Go held high with Op=010, in1=6, in2=3 → out=2; Go kept high → the next operation starts one cycle after DONE.
